// File: rtl/mips_ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline boundary.
// Optional feature: MIPS_EX_MEM_SKID_EN selects the 2-entry skid buffer;
// when it is undefined the stage is a single pipeline register.
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif

package mips_ex_mem_pkg;

    // Memory access size encoding as carried on ex_mem_size / mem_size.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_e;

    // Number of beats the stage can hold.
`ifdef MIPS_EX_MEM_SKID_EN
    localparam int unsigned EX_MEM_DEPTH = 2;
`else
    localparam int unsigned EX_MEM_DEPTH = 1;
`endif

    // Control part of a beat record. The wide data fields (result, store
    // data, destination index) are parameterised in the top and travel
    // alongside this record.
    typedef struct packed {
        logic      wen;       // writeback enable as issued by EX
        logic      mem_rd;    // load
        logic      mem_wr;    // store
        mem_size_e size;      // access size
        logic      ovf;       // signed overflow from EX
        logic      misalign;  // captured at push time
    } beat_ctrl_t;

    localparam int unsigned BEAT_CTRL_W = $bits(beat_ctrl_t);

    // A memory access is misaligned when a word is not 4-byte aligned or a
    // halfword is not 2-byte aligned. Non-memory beats are never flagged.
    function automatic logic is_misaligned(input mem_size_e  size,
                                           input logic [1:0] addr_lo,
                                           input logic       access);
        logic bad;
        bad = 1'b0;
        if (size == WORD && addr_lo != 2'b00) begin
            bad = 1'b1;
        end
        if (size == HALF && addr_lo[0]) begin
            bad = 1'b1;
        end
        return bad & access;
    endfunction

endpackage

// File: rtl/mips_ex_mem_skid.sv
// Generic valid/ready buffer between EX and MEM.
// MIPS_EX_MEM_SKID_EN defined: 2-entry FIFO whose in_ready is decoded from
// registers only. Undefined: single register with combinational in_ready.
// flush empties the buffer at the next edge, overriding push and pop.
module mips_ex_mem_skid
    import mips_ex_mem_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic push;
    logic pop;

`ifdef MIPS_EX_MEM_SKID_EN

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // Ready depends only on the held count, so no mem_ready path reaches EX.
    assign in_ready  = (count_q < 2'(EX_MEM_DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`else

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A held beat leaving this cycle frees the register for a new one.
    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state for the single pipeline register.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`endif

endmodule

// File: rtl/mips_ex_mem_stage.sv
// EX/MEM pipeline stage: buffers EX result beats, flags misalignment at push,
// suppresses side effects of faulting beats, raises exception pulses at pop
// and drives the MEM->EX forwarding and load-hazard signals from the head.
// MIPS_EX_MEM_SKID_EN selects the 2-entry skid buffer (default: 1 register).
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif

module mips_ex_mem_stage
    import mips_ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = `MIPS_DATA_WIDTH,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [DATA_W-1:0]  ex_res,
    input  logic [DATA_W-1:0]  ex_store_data,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_wen,
    input  logic               ex_mem_rd,
    input  logic               ex_mem_wr,
    input  logic [1:0]         ex_mem_size,
    input  logic               ex_ovf,
    input  logic               flush,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [DATA_W-1:0]  mem_res,
    output logic [DATA_W-1:0]  mem_store_data,
    output logic [RADDR_W-1:0] mem_rd,
    output logic               mem_wen,
    output logic               mem_rd_en,
    output logic               mem_wr_en,
    output logic [1:0]         mem_size,
    output logic               excp_ovf,
    output logic               excp_align,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               load_hazard
);

    localparam int unsigned BEAT_W = 2 * DATA_W + RADDR_W + BEAT_CTRL_W;

    beat_ctrl_t         in_ctrl;
    beat_ctrl_t         head_ctrl;
    logic [BEAT_W-1:0]  in_beat;
    logic [BEAT_W-1:0]  head_beat;
    logic [DATA_W-1:0]  head_res;
    logic [DATA_W-1:0]  head_sd;
    logic [RADDR_W-1:0] head_rd;
    logic               head_fault;
    logic               pop;

    // Build the control record of the incoming beat; misalignment is
    // resolved here so the head never needs the full address compare.
    always_comb begin
        in_ctrl          = '0;
        in_ctrl.wen      = ex_wen;
        in_ctrl.mem_rd   = ex_mem_rd;
        in_ctrl.mem_wr   = ex_mem_wr;
        in_ctrl.size     = mem_size_e'(ex_mem_size);
        in_ctrl.ovf      = ex_ovf;
        in_ctrl.misalign = is_misaligned(mem_size_e'(ex_mem_size), ex_res[1:0],
                                         ex_mem_rd | ex_mem_wr);
    end

    assign in_beat = {ex_res, ex_store_data, ex_rd, in_ctrl};

    mips_ex_mem_skid #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (ex_valid),
        .in_ready  (ex_ready),
        .in_data   (in_beat),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .out_data  (head_beat)
    );

    assign {head_res, head_sd, head_rd, head_ctrl} = head_beat;

    // Faulting beats keep flowing to MEM but with every side effect masked.
    always_comb begin
        head_fault     = head_ctrl.ovf | head_ctrl.misalign;
        mem_res        = head_res;
        mem_store_data = head_sd;
        mem_rd         = head_rd;
        mem_size       = head_ctrl.size;
        mem_wen        = head_ctrl.wen    & ~head_fault;
        mem_rd_en      = head_ctrl.mem_rd & ~head_fault;
        mem_wr_en      = head_ctrl.mem_wr & ~head_fault;
    end

    // Exceptions fire only in the cycle the beat actually leaves; a beat
    // discarded by flush never raises one. Overflow wins over alignment.
    always_comb begin
        pop        = mem_valid & mem_ready & ~flush;
        excp_ovf   = pop & head_ctrl.ovf;
        excp_align = pop & ~head_ctrl.ovf & head_ctrl.misalign;
    end

    // Forward ALU results only; loads are not yet resolved and r0 is never
    // a valid forwarding target even though its writeback passes through.
    always_comb begin
        fwd_valid   = mem_valid & mem_wen & ~mem_rd_en & (head_rd != '0);
        fwd_rd      = head_rd;
        fwd_data    = head_res;
        load_hazard = mem_valid & mem_rd_en;
    end

endmodule

// File: tb/tb_mips_ex_mem_stage.sv
// Directed self-checking bench for mips_ex_mem_stage.
// Expectations adapt to MIPS_EX_MEM_SKID_EN (depth 2) or the default (depth 1).
`timescale 1ns/1ps

module tb_mips_ex_mem_stage;

`ifdef MIPS_EX_MEM_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_res;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [1:0]  ex_mem_size;
    logic        ex_ovf;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_res;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_wen;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [1:0]  mem_size;
    logic        excp_ovf;
    logic        excp_align;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_hazard;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_ex_mem_stage #(
        .DATA_W  (32),
        .RADDR_W (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_res         (ex_res),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_wen         (ex_wen),
        .ex_mem_rd      (ex_mem_rd),
        .ex_mem_wr      (ex_mem_wr),
        .ex_mem_size    (ex_mem_size),
        .ex_ovf         (ex_ovf),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_res        (mem_res),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_wen        (mem_wen),
        .mem_rd_en      (mem_rd_en),
        .mem_wr_en      (mem_wr_en),
        .mem_size       (mem_size),
        .excp_ovf       (excp_ovf),
        .excp_align     (excp_align),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .load_hazard    (load_hazard)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge (output sample point).
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_beat(input logic [31:0] res, input logic [4:0] rd, input logic wen,
                            input logic mrd, input logic mwr, input logic [1:0] size,
                            input logic ovf);
        ex_valid      = 1'b1;
        ex_res        = res;
        ex_store_data = ~res;
        ex_rd         = rd;
        ex_wen        = wen;
        ex_mem_rd     = mrd;
        ex_mem_wr     = mwr;
        ex_mem_size   = size;
        ex_ovf        = ovf;
    endtask

    task automatic idle();
        ex_valid  = 1'b0;
        ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0;
        ex_ovf    = 1'b0;
    endtask

    logic [31:0] vals [3];

    initial begin
        vals[0] = 32'h0000_00A0;
        vals[1] = 32'h0000_00B4;
        vals[2] = 32'h0000_00C8;

        rst_n = 1'b0;
        flush = 1'b0;
        mem_ready = 1'b0;
        set_beat(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        idle();

        // Reset state
        #12;
        check_eq("rst_mem_valid", mem_valid, 0);
        check_eq("rst_fwd_valid", fwd_valid, 0);
        check_eq("rst_load_hazard", load_hazard, 0);
        check_eq("rst_excp", {excp_ovf, excp_align}, 0);
        check_eq("rst_mem_res", mem_res, 0);
        mid();
        rst_n = 1'b1;
        step();
        check_eq("rst_ex_ready", ex_ready, 1);

        // Basic ALU beat with forwarding
        mem_ready = 1'b1;
        set_beat(32'h0000_1000, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        mid();
        check_eq("alu_empty", mem_valid, 0);
        step();
        idle();
        mid();
        check_eq("alu_valid", mem_valid, 1);
        check_eq("alu_fwd_valid", fwd_valid, 1);
        check_eq("alu_fwd_rd", fwd_rd, 3);
        check_eq("alu_fwd_data", fwd_data, 32'h0000_1000);
        check_eq("alu_store_data", mem_store_data, 32'hFFFF_EFFF);
        step();
        mid();
        check_eq("alu_drained", mem_valid, 0);

        // Back-pressure: only DEPTH beats accepted, then in-order drain
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(vals[i], 5'(i + 1), 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
            mid();
            check_eq($sformatf("bp_ready_%0d", i), ex_ready, (i < DEPTH) ? 1 : 0);
            step();
        end
        idle();
        mem_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            mid();
            check_eq($sformatf("bp_out_valid_%0d", i), mem_valid, 1);
            check_eq($sformatf("bp_out_res_%0d", i), mem_res, vals[i]);
            step();
        end
        mid();
        check_eq("bp_empty", mem_valid, 0);
        step();
        for (int i = DEPTH; i < 3; i++) begin
            set_beat(vals[i], 5'(i + 1), 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
            step();
            idle();
            mid();
            check_eq($sformatf("bp_late_res_%0d", i), mem_res, vals[i]);
            check_eq($sformatf("bp_late_rd_%0d", i), mem_rd, i + 1);
            step();
        end

        // Misaligned word load
        set_beat(32'h0000_1002, 5'd4, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        step();
        idle();
        mid();
        check_eq("lw_mis_rd_en", mem_rd_en, 0);
        check_eq("lw_mis_wen", mem_wen, 0);
        check_eq("lw_mis_align", excp_align, 1);
        check_eq("lw_mis_ovf", excp_ovf, 0);
        check_eq("lw_mis_hazard", load_hazard, 0);
        step();
        mid();
        check_eq("lw_mis_align_once", excp_align, 0);

        // Aligned word load
        step();
        set_beat(32'h0000_1004, 5'd4, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        step();
        idle();
        mid();
        check_eq("lw_ok_rd_en", mem_rd_en, 1);
        check_eq("lw_ok_hazard", load_hazard, 1);
        check_eq("lw_ok_fwd", fwd_valid, 0);
        check_eq("lw_ok_align", excp_align, 0);
        check_eq("lw_ok_size", mem_size, 2);

        // Misaligned halfword store, then odd-address byte load
        step();
        set_beat(32'h0000_1001, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        step();
        idle();
        mid();
        check_eq("sh_mis_wr_en", mem_wr_en, 0);
        check_eq("sh_mis_align", excp_align, 1);
        step();
        set_beat(32'h0000_1003, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        step();
        idle();
        mid();
        check_eq("lb_odd_rd_en", mem_rd_en, 1);
        check_eq("lb_odd_align", excp_align, 0);

        // Overflow: masked writeback, pulse only at pop
        step();
        mem_ready = 1'b0;
        set_beat(32'h7FFF_FFFF, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
        step();
        idle();
        mid();
        check_eq("ovf_held_valid", mem_valid, 1);
        check_eq("ovf_held_pulse", excp_ovf, 0);
        check_eq("ovf_wen", mem_wen, 0);
        check_eq("ovf_fwd", fwd_valid, 0);
        step();
        mem_ready = 1'b1;
        mid();
        check_eq("ovf_pulse", excp_ovf, 1);
        step();
        mid();
        check_eq("ovf_pulse_once", excp_ovf, 0);
        check_eq("ovf_drained", mem_valid, 0);

        // Overflow on a misaligned load: only the overflow pulse
        step();
        set_beat(32'h0000_1002, 5'd6, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
        step();
        idle();
        mid();
        check_eq("ovf_prio_ovf", excp_ovf, 1);
        check_eq("ovf_prio_align", excp_align, 0);

        // Write to r0 passes through but never forwards
        step();
        set_beat(32'h0000_0055, 5'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        step();
        idle();
        mid();
        check_eq("r0_wen", mem_wen, 1);
        check_eq("r0_fwd", fwd_valid, 0);

        // Flush a full buffer with a simultaneous push and pop
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_beat(vals[i], 5'd9, 1'b1, 1'b0, 1'b0, 2'd2, (i == 0) ? 1'b1 : 1'b0);
            step();
        end
        set_beat(32'h0000_0DEF, 5'd10, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        flush = 1'b1;
        mem_ready = 1'b1;
        mid();
        check_eq("flush_no_ovf", excp_ovf, 0);
        step();
        flush = 1'b0;
        idle();
        mem_ready = 1'b0;
        mid();
        check_eq("flush_empty", mem_valid, 0);
        check_eq("flush_ready", ex_ready, 1);
        check_eq("flush_no_excp", {excp_ovf, excp_align}, 0);

        // Asynchronous reset with beats held
        step();
        for (int i = 0; i < DEPTH; i++) begin
            set_beat(32'h0000_2000 + 32'(i * 4), 5'd6, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
            step();
        end
        idle();
        mid();
        check_eq("arst_pre_hazard", load_hazard, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", mem_valid, 0);
        check_eq("arst_hazard", load_hazard, 0);
        check_eq("arst_fwd", fwd_valid, 0);
        check_eq("arst_res", mem_res, 0);
        mid();
        rst_n = 1'b1;
        step();
        mid();
        check_eq("arst_ready", ex_ready, 1);
        check_eq("arst_empty", mem_valid, 0);
        check_eq("arst_excp", {excp_ovf, excp_align}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_ex_mem_stage.md
MIPS_EX_MEM_STAGE -- requirements
Module: mips_ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default `MIPS_DATA_WIDTH (32), meaning the datapath width.
REQ-002 SHALL have parameter RADDR_W, default 5, meaning the register-file index width.
REQ-003 SHALL have clock and reset as decided: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ex_valid  in  1  EX result beat valid.
REQ-007 ex_ready  out  1  stage can accept a beat.
REQ-008 ex_res  in  DATA_W  ALU result or AGU address.
REQ-009 ex_store_data  in  DATA_W  store data.
REQ-010 ex_rd / ex_wen  in  RADDR_W / 1  destination register and writeback enable.
REQ-011 ex_mem_rd / ex_mem_wr / ex_mem_size  in  1/1/2  load, store, size (0 byte, 1 half, 2 word).
REQ-012 ex_ovf  in  1  signed add/sub overflow from EX.
REQ-013 flush  in  1  kill all held beats.
REQ-014 mem_valid / mem_ready  out/in  1/1  MEM-side handshake.
REQ-015 mem_res, mem_store_data, mem_rd, mem_wen, mem_rd_en, mem_wr_en, mem_size  out  as EX  head-beat fields.
REQ-016 excp_ovf / excp_align  out  1/1  one-cycle exception pulses.
REQ-017 fwd_valid / fwd_rd / fwd_data  out  1/RADDR_W/DATA_W  forwarding to EX.
REQ-018 load_hazard  out  1  head beat is a load.

Function
REQ-019 Push SHALL occur on ex_valid & ex_ready; pop SHALL occur on mem_valid & mem_ready.
REQ-020 A beat pushed in cycle N SHALL appear at mem_valid in cycle N+1 (empty buffer); beats SHALL leave in push order.
REQ-021 With skid enabled, ex_ready SHALL be 1 iff fewer than 2 entries are held, decoded from registers only (no combinational mem_ready path).
REQ-022 Push and pop in the same cycle with 1 entry SHALL leave the count at 1; when full, no push SHALL occur.
REQ-023 Misalignment SHALL be flagged at push: (size 2 & res[1:0]!=0) or (size 1 & res[0]) with rd or wr set.
REQ-024 An entry with ovf or misalignment SHALL present mem_wen=0, mem_rd_en=0, mem_wr_en=0.
REQ-025 excp_ovf / excp_align SHALL pulse for exactly the pop cycle of the offending entry; ovf has priority, only one pulse per entry.
REQ-026 fwd_valid SHALL equal mem_valid & mem_wen & ~mem_rd_en & (mem_rd!=0); fwd_rd/fwd_data SHALL be the head's rd/res.
REQ-027 load_hazard SHALL equal mem_valid & mem_rd_en.
REQ-028 flush SHALL empty all entries at the next edge, overriding a simultaneous push and pop; no exception pulse SHALL be produced for flushed beats.
REQ-029 Writes to rd 0 SHALL pass through with mem_wen unchanged but SHALL never forward.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously clear count and pointers; mem_valid, fwd_valid, load_hazard, excp_ovf, excp_align SHALL be 0.
REQ-031 ex_ready SHALL be 1 from the first cycle after reset deassertion; data fields SHALL reset to 0.
REQ-032 Reset mid-transfer SHALL discard all held beats without exceptions.

Configuration
REQ-033 Macro MIPS_EX_MEM_SKID_EN defined: 2-entry skid buffer per REQ-021/022.
REQ-034 Macro undefined: single register, ex_ready = ~mem_valid | mem_ready (combinational), all other behaviour identical.

Structure
REQ-035 The beat record typedef, size encodings (BYTE/HALF/WORD) and entry depth constant SHALL live in shared package mips_ex_mem_pkg.
REQ-036 The buffer SHALL be a sub-module mips_ex_mem_skid (generic 2-entry valid/ready FIFO); alignment/exception and forwarding logic SHALL stay in the top.

Verification
REQ-037 Push res=0x1000, rd=3, wen=1, mem_ready=1 -> mem_valid next cycle, fwd_valid=1, fwd_rd=3, fwd_data=0x1000, count returns to 0.
REQ-038 mem_ready=0, push 3 beats back-to-back -> ex_ready=0 after 2nd (skid on), 3rd held off; release -> beats exit in order, no loss.
REQ-039 Load word res=0x1002 -> mem_rd_en=0, excp_align pulses once at pop; load res=0x1004 -> load_hazard=1, fwd_valid=0.
REQ-040 Push ovf=1, rd=5, wen=1 -> mem_wen=0, fwd_valid=0, excp_ovf single pulse at pop.
REQ-041 Full buffer, flush with simultaneous ex_valid -> mem_valid=0 next cycle, no excp pulses, ex_ready=1.
REQ-042 rst_n low while 2 entries held -> outputs cleared immediately; after release, ex_ready=1, mem_valid=0.
